// File: rtl/bit_serial_alu_seq.sv
// Sequencer that runs a WIDTH-bit ALU operation through one shared 1-bit slice, LSB first.
// Optional slice self-check is enabled by defining BSALU_SLICE_CHECK_EN (adds slice_err).
module bit_serial_alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result,
   output logic             zero_flag,
   output logic             cout,
   output logic             ovf,
   output logic             slice_a,
   output logic             slice_b,
   output logic             slice_ainvert,
   output logic             slice_binvert,
   output logic [1:0]       slice_op,
   output logic             slice_cy_in,
   input  logic             slice_result,
   input  logic             slice_cout
`ifdef BSALU_SLICE_CHECK_EN
   ,
   output logic             slice_err
`endif
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_NAND = 3'b100;
   localparam logic [2:0] OP_NOR  = 3'b101;
   localparam logic [2:0] OP_SLT  = 3'b110;
   localparam logic [2:0] OP_RSVD = 3'b111;

   localparam logic [1:0] SOP_AND = 2'b00;
   localparam logic [1:0] SOP_OR  = 2'b01;
   localparam logic [1:0] SOP_ADD = 2'b10;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [2:0]       opc_q, opc_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;

   logic             ctl_ainv;
   logic             ctl_binv;
   logic [1:0]       ctl_op;
   logic             ctl_cin0;
   logic             is_arith;
   logic             is_addsub;

   logic [WIDTH-1:0] acc_next;
   logic             msb_ovf;
   logic             slt_bit;
   logic [WIDTH-1:0] final_res;

   always_comb begin
      ctl_ainv  = 1'b0;
      ctl_binv  = 1'b0;
      ctl_op    = SOP_AND;
      ctl_cin0  = 1'b0;
      is_arith  = 1'b0;
      is_addsub = 1'b0;
      case (opc_q)
         OP_OR: begin
            ctl_op = SOP_OR;
         end
         OP_ADD: begin
            ctl_op    = SOP_ADD;
            is_arith  = 1'b1;
            is_addsub = 1'b1;
         end
         OP_SUB: begin
            ctl_binv  = 1'b1;
            ctl_op    = SOP_ADD;
            ctl_cin0  = 1'b1;
            is_arith  = 1'b1;
            is_addsub = 1'b1;
         end
         OP_NAND: begin
            ctl_ainv = 1'b1;
            ctl_binv = 1'b1;
            ctl_op   = SOP_OR;
         end
         OP_NOR: begin
            ctl_ainv = 1'b1;
            ctl_binv = 1'b1;
            ctl_op   = SOP_AND;
         end
         OP_SLT: begin
            ctl_binv = 1'b1;
            ctl_op   = SOP_ADD;
            ctl_cin0 = 1'b1;
            is_arith = 1'b1;
         end
         default: begin
            ctl_op = SOP_AND;
         end
      endcase
   end

   // The slice is only driven while running; elsewhere every control line idles at 0.
   always_comb begin
      slice_a       = 1'b0;
      slice_b       = 1'b0;
      slice_ainvert = 1'b0;
      slice_binvert = 1'b0;
      slice_op      = 2'b00;
      slice_cy_in   = 1'b0;
      if (state_q == ST_RUN) begin
         slice_a       = a_q[idx_q];
         slice_b       = b_q[idx_q];
         slice_ainvert = ctl_ainv;
         slice_binvert = ctl_binv;
         slice_op      = ctl_op;
         slice_cy_in   = (idx_q == '0) ? ctl_cin0 : carry_q;
      end
   end

   // On the last bit the MSB carry-in/out are live on the slice, so flags come from there.
   always_comb begin
      acc_next         = acc_q;
      acc_next[idx_q]  = slice_result;
      msb_ovf          = slice_cy_in ^ slice_cout;
      slt_bit          = acc_next[WIDTH-1] ^ msb_ovf;
      if (opc_q == OP_SLT) begin
         final_res = {{(WIDTH-1){1'b0}}, slt_bit};
      end else begin
         final_res = acc_next;
      end
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      opc_d    = opc_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      acc_d    = acc_q;
      result_d = result_q;
      zero_d   = zero_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               opc_d   = opcode;
               idx_d   = '0;
               carry_d = 1'b0;
               acc_d   = '0;
               if (opcode == OP_RSVD) begin
                  state_d  = ST_DONE;
                  result_d = '0;
                  zero_d   = 1'b1;
                  cout_d   = 1'b0;
                  ovf_d    = 1'b0;
                  err_d    = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            acc_d   = acc_next;
            carry_d = slice_cout;
            idx_d   = idx_q + IW'(1);
            if (idx_q == LAST_IDX) begin
               state_d  = ST_DONE;
               result_d = final_res;
               zero_d   = (final_res == '0);
               cout_d   = is_arith ? slice_cout : 1'b0;
               ovf_d    = is_addsub ? msb_ovf : 1'b0;
               err_d    = 1'b0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         opc_q    <= '0;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         acc_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         opc_q    <= opc_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
      end
   end

`ifdef BSALU_SLICE_CHECK_EN
   // Reference slice: the same invert/op/full-adder function the external slice should implement.
   logic slice_err_q, slice_err_d;
   logic chk_a;
   logic chk_b;
   logic chk_sum;
   logic chk_res;
   logic chk_cout;
   logic chk_mismatch;

   always_comb begin
      chk_a    = slice_a ^ slice_ainvert;
      chk_b    = slice_b ^ slice_binvert;
      chk_sum  = chk_a ^ chk_b ^ slice_cy_in;
      chk_cout = (chk_a & chk_b) | (chk_a & slice_cy_in) | (chk_b & slice_cy_in);
      case (slice_op)
         SOP_AND: chk_res = chk_a & chk_b;
         SOP_OR:  chk_res = chk_a | chk_b;
         SOP_ADD: chk_res = chk_sum;
         default: chk_res = 1'b0;
      endcase
      chk_mismatch = (state_q == ST_RUN) &&
                     ((chk_res != slice_result) || (chk_cout != slice_cout));
   end

   always_comb begin
      slice_err_d = slice_err_q;
      if ((state_q == ST_IDLE) && start) begin
         slice_err_d = 1'b0;
      end else if (chk_mismatch) begin
         slice_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slice_err_q <= 1'b0;
      end else begin
         slice_err_q <= slice_err_d;
      end
   end

   assign slice_err = slice_err_q;
`endif

   assign busy      = (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);
   assign err       = err_q;
   assign result    = result_q;
   assign zero_flag = zero_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Self-checking bench for bit_serial_alu_seq (WIDTH=8) with a behavioural 1-bit slice and a
// scoreboard of expected results; BSALU_SLICE_CHECK_EN adds the slice-fault scenario.
module tb_bit_serial_alu_seq;

   localparam int W = 8;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_NAND = 3'b100;
   localparam logic [2:0] OP_NOR  = 3'b101;
   localparam logic [2:0] OP_SLT  = 3'b110;
   localparam logic [2:0] OP_RSVD = 3'b111;

   typedef struct packed {
      logic [W-1:0] res;
      logic         z;
      logic         c;
      logic         v;
      logic         e;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [2:0]   opcode;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic         err;
   logic [W-1:0] result;
   logic         zero_flag;
   logic         cout;
   logic         ovf;
   logic         slice_a;
   logic         slice_b;
   logic         slice_ainvert;
   logic         slice_binvert;
   logic [1:0]   slice_op;
   logic         slice_cy_in;
   logic         slice_result;
   logic         slice_cout;
   logic         fault;
`ifdef BSALU_SLICE_CHECK_EN
   logic         slice_err;
`endif

   int   checks;
   int   passed;
   exp_t scoreboard[$];

   bit_serial_alu_seq #(.WIDTH(W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .opcode        (opcode),
      .a             (a),
      .b             (b),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .result        (result),
      .zero_flag     (zero_flag),
      .cout          (cout),
      .ovf           (ovf),
      .slice_a       (slice_a),
      .slice_b       (slice_b),
      .slice_ainvert (slice_ainvert),
      .slice_binvert (slice_binvert),
      .slice_op      (slice_op),
      .slice_cy_in   (slice_cy_in),
      .slice_result  (slice_result),
      .slice_cout    (slice_cout)
`ifdef BSALU_SLICE_CHECK_EN
      ,
      .slice_err     (slice_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model of the external 1-bit ALU slice; fault inverts its result bit.
   always_comb begin
      logic sa, sb;
      logic r;
      sa = slice_a ^ slice_ainvert;
      sb = slice_b ^ slice_binvert;
      case (slice_op)
         2'b00:   r = sa & sb;
         2'b01:   r = sa | sb;
         2'b10:   r = sa ^ sb ^ slice_cy_in;
         default: r = 1'b0;
      endcase
      slice_result = r ^ fault;
      slice_cout   = (sa & sb) | (sa & slice_cy_in) | (sb & slice_cy_in);
   end

   // Word-level reference computed directly from the operand values.
   function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t     m;
      logic [W:0] s;
      m = '0;
      s = '0;
      case (op)
         OP_AND:  m.res = x & y;
         OP_OR:   m.res = x | y;
         OP_NAND: m.res = ~(x & y);
         OP_NOR:  m.res = ~(x | y);
         OP_ADD: begin
            s     = {1'b0, x} + {1'b0, y};
            m.res = s[W-1:0];
            m.c   = s[W];
            m.v   = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
         end
         OP_SUB: begin
            s     = {1'b0, x} + {1'b0, ~y} + 9'd1;
            m.res = s[W-1:0];
            m.c   = s[W];
            m.v   = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
         end
         OP_SLT: begin
            s     = {1'b0, x} + {1'b0, ~y} + 9'd1;
            m.c   = s[W];
            m.res = ($signed(x) < $signed(y)) ? 8'd1 : 8'd0;
         end
         default: m.e = 1'b1;
      endcase
      m.z = (m.res == '0);
      return m;
   endfunction

   function automatic string show(input exp_t v);
      return $sformatf("res=%h z=%b c=%b v=%b e=%b", v.res, v.z, v.c, v.v, v.e);
   endfunction

   // Pushes the expected result, issues one start, scrambles inputs after acceptance and waits for done.
   task automatic do_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        output exp_t obs, output int lat);
      scoreboard.push_back(model(op, x, y));
      @(negedge clk);
      start  = 1'b1;
      opcode = op;
      a      = x;
      b      = y;
      @(posedge clk);
      #1;
      start  = 1'b0;
      a      = W'($urandom);
      b      = W'($urandom);
      opcode = 3'($urandom);
      lat    = -1;
      obs    = 'x;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (done) begin
            lat = n;
            obs = {result, zero_flag, cout, ovf, err};
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [23:0] outs;
      #1;
      outs = {busy, done, err, result, zero_flag, cout, ovf, slice_a, slice_b,
              slice_ainvert, slice_binvert, slice_op, slice_cy_in};
      checks++;
      if (outs !== '0) $display("[TB] FAIL reset_outputs: got %h, expected 0", outs);
      else passed++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_arith();
      logic [2:0]   ops [7] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_SLT, OP_SLT, OP_SLT};
      logic [W-1:0] xs  [7] = '{8'h7F, 8'hFF, 8'h05, 8'h00, 8'h80, 8'h01, 8'h7F};
      logic [W-1:0] ys  [7] = '{8'h01, 8'h01, 8'h05, 8'h01, 8'h01, 8'h80, 8'h80};
      exp_t obs, e;
      int   lat;
      for (int i = 0; i < 7; i++) begin
         do_op(ops[i], xs[i], ys[i], obs, lat);
         e = scoreboard.pop_front();
         checks++;
         if (obs !== e) $display("[TB] FAIL arith_%0d: got %s, expected %s", i, show(obs), show(e));
         else passed++;
         checks++;
         if (lat !== W + 1) $display("[TB] FAIL arith_latency_%0d: got %0d, expected %0d", i, lat, W + 1);
         else passed++;
      end
   endtask

   task automatic test_logic();
      logic [2:0]   ops [5] = '{OP_NAND, OP_NOR, OP_AND, OP_OR, OP_NOR};
      logic [W-1:0] xs  [5] = '{8'hFF, 8'hF0, 8'hCC, 8'hCC, 8'h21};
      logic [W-1:0] ys  [5] = '{8'hFF, 8'h0F, 8'hAA, 8'hAA, 8'h04};
      exp_t obs, e;
      int   lat;
      for (int i = 0; i < 5; i++) begin
         do_op(ops[i], xs[i], ys[i], obs, lat);
         e = scoreboard.pop_front();
         checks++;
         if (obs !== e) $display("[TB] FAIL logic_%0d: got %s, expected %s", i, show(obs), show(e));
         else passed++;
      end
      @(negedge clk);
      checks++;
      if (result !== e.res || done !== 1'b0)
         $display("[TB] FAIL logic_hold: got res=%h done=%b, expected res=%h done=0", result, done, e.res);
      else passed++;
   endtask

   task automatic test_reserved();
      exp_t obs, e;
      int   lat;
      do_op(OP_RSVD, 8'h5A, 8'hA5, obs, lat);
      e = scoreboard.pop_front();
      checks++;
      if (obs !== e) $display("[TB] FAIL reserved: got %s, expected %s", show(obs), show(e));
      else passed++;
      checks++;
      if (lat !== 1) $display("[TB] FAIL reserved_latency: got %0d, expected 1", lat);
      else passed++;
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || done !== 1'b0)
         $display("[TB] FAIL reserved_clear: got err=%b done=%b, expected 0 0", err, done);
      else passed++;
   endtask

   task automatic test_start_held();
      exp_t obs, e;
      int   ndone;
      scoreboard.push_back(model(OP_ADD, 8'h3C, 8'h41));
      ndone = 0;
      obs   = 'x;
      @(negedge clk);
      start  = 1'b1;
      opcode = OP_ADD;
      a      = 8'h3C;
      b      = 8'h41;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (n == 3) begin
            a = 8'hFF;
            b = 8'hFF;
         end
         if (done) begin
            ndone++;
            if (ndone == 1) obs = {result, zero_flag, cout, ovf, err};
            start = 1'b0;
         end
      end
      e = scoreboard.pop_front();
      checks++;
      if (ndone !== 1) $display("[TB] FAIL held_done_count: got %0d, expected 1", ndone);
      else passed++;
      checks++;
      if (obs !== e) $display("[TB] FAIL held_result: got %s, expected %s", show(obs), show(e));
      else passed++;
   endtask

   task automatic test_reset_mid_run();
      logic [23:0] outs;
      exp_t obs, e;
      int   lat;
      int   ndone;
      @(negedge clk);
      start  = 1'b1;
      opcode = OP_ADD;
      a      = 8'h55;
      b      = 8'h22;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (busy !== 1'b1) $display("[TB] FAIL midrun_busy: got %b, expected 1", busy);
      else passed++;
      rst_n = 1'b0;
      #1;
      outs = {busy, done, err, result, zero_flag, cout, ovf, slice_a, slice_b,
              slice_ainvert, slice_binvert, slice_op, slice_cy_in};
      checks++;
      if (outs !== '0) $display("[TB] FAIL midrun_reset_outputs: got %h, expected 0", outs);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      checks++;
      if (ndone !== 0) $display("[TB] FAIL midrun_no_done: got %0d, expected 0", ndone);
      else passed++;
      do_op(OP_ADD, 8'h12, 8'h34, obs, lat);
      e = scoreboard.pop_front();
      checks++;
      if (obs !== e) $display("[TB] FAIL after_reset_add: got %s, expected %s", show(obs), show(e));
      else passed++;
   endtask

   task automatic test_back_to_back();
      exp_t obs [2];
      exp_t e;
      int   when [2];
      int   ndone;
      scoreboard.push_back(model(OP_SUB, 8'h30, 8'h70));
      scoreboard.push_back(model(OP_SUB, 8'h30, 8'h70));
      ndone   = 0;
      when[0] = -1;
      when[1] = -1;
      obs[0]  = 'x;
      obs[1]  = 'x;
      @(negedge clk);
      start  = 1'b1;
      opcode = OP_SUB;
      a      = 8'h30;
      b      = 8'h70;
      for (int n = 1; n <= 40 && ndone < 2; n++) begin
         @(negedge clk);
         if (done) begin
            obs[ndone]  = {result, zero_flag, cout, ovf, err};
            when[ndone] = n;
            ndone++;
            if (ndone == 2) start = 1'b0;
         end
      end
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         e = scoreboard.pop_front();
         checks++;
         if (obs[i] !== e) $display("[TB] FAIL b2b_%0d: got %s, expected %s", i, show(obs[i]), show(e));
         else passed++;
      end
      checks++;
      if (when[1] - when[0] !== W + 2 || when[0] < 0)
         $display("[TB] FAIL b2b_spacing: got %0d, expected %0d", when[1] - when[0], W + 2);
      else passed++;
      @(negedge clk);
   endtask

`ifdef BSALU_SLICE_CHECK_EN
   task automatic test_slice_check();
      exp_t obs, e;
      int   lat;
      fault = 1'b1;
      do_op(OP_AND, 8'hCC, 8'hAA, obs, lat);
      e = scoreboard.pop_front();
      checks++;
      if (slice_err !== 1'b1) $display("[TB] FAIL slice_err_set: got %b, expected 1", slice_err);
      else passed++;
      fault = 1'b0;
      do_op(OP_OR, 8'hCC, 8'hAA, obs, lat);
      e = scoreboard.pop_front();
      checks++;
      if (slice_err !== 1'b0 || obs !== e)
         $display("[TB] FAIL slice_err_clear: got err=%b %s, expected err=0 %s", slice_err, show(obs), show(e));
      else passed++;
   endtask
`endif

   initial begin
      checks = 0;
      passed = 0;
      fault  = 1'b0;
      rst_n  = 1'b0;
      start  = 1'b0;
      opcode = '0;
      a      = '0;
      b      = '0;
      test_reset();
      test_arith();
      test_logic();
      test_reserved();
      test_start_held();
      test_reset_mid_run();
      test_back_to_back();
`ifdef BSALU_SLICE_CHECK_EN
      test_slice_check();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
